hack_pc_fetch: RTL and testbench
================================

Name: hack_pc_fetch

Overview:
- Program-counter and instruction-fetch stage of the Hack CPU.
- Holds the PC and fetches from instruction ROM using a req/ack handshake.
- Presents each instruction downstream using a valid/ready handshake.
- At each retire, evaluates the C-instruction jump condition against the ALU flags and chooses either PC+1 or the A-register value, which comes from the A-input 16-bit 2-way mux.

Parameters:
- WIDTH, 16, data and address width.
- RESET_ADDR, 16'h0000, PC value after reset and after restart.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rom_addr  out  WIDTH  fetch address, equal to the current PC.
- rom_req  out  1  fetch request; high only in FETCH.
- rom_ack  in  1  ROM has data on rom_data this cycle.
- rom_data  in  WIDTH  instruction word from ROM.
- instr  out  WIDTH  latched instruction.
- instr_valid  out  1  instr is valid; high only in HOLD.
- instr_ready  in  1  execute stage retires instr this cycle.
- a_in  in  WIDTH  A-register value, used as the jump target.
- zr  in  1  ALU result is zero.
- ng  in  1  ALU result is negative.
- restart  in  1  synchronous program restart.
- halted  out  1  tight-loop halt detected (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_ADDR, instr=0.
  - rom_req=0, instr_valid=0, halted=0.
  - Outputs change immediately on assertion, regardless of clk.
- States:
  - IDLE: unconditionally goes to FETCH next cycle. This gives one idle cycle after reset release.
  - FETCH: rom_req=1, rom_addr=pc. When rom_ack=1: instr<=rom_data and go to HOLD. With no ack, stay in FETCH and keep rom_req high and rom_addr stable.
  - HOLD: instr_valid=1; instr and rom_addr held stable. When instr_ready=1 (retire), update pc and go to FETCH. Otherwise stay.
- Minimum latency: FETCH with ack → HOLD next cycle → retire → FETCH of the next address in the following cycle. That is 2 cycles per instruction when ack and ready are both immediate.
- Next-PC at retire, in priority order:
  1. restart=1 → RESET_ADDR.
  2. Jump taken → a_in, sampled in the retire cycle.
  3. Otherwise pc+1, modulo 2^WIDTH, so 16'hFFFF wraps to 16'h0000 with no flag.
- Jump taken condition:
  - is_c = instr[15]; j = instr[2:0].
  - taken = is_c & ((j[2]&ng) | (j[1]&zr) | (j[0]&~ng&~zr)).
  - j=3'b111 is always taken; j=3'b000 is never taken.
  - A-instructions (instr[15]=0) are never taken, whatever bits [2:0] hold.
- zr, ng, a_in and restart are sampled only in the retire cycle and ignored at all other times.
- rom_ack outside FETCH is ignored; it is not latched. instr_ready outside HOLD is ignored.
- Reset mid-fetch abandons the request. Fetch restarts at RESET_ADDR after the IDLE cycle.

Optional Feature:
- Macro: HACK_PC_HALT_DETECT_EN.
- With the macro:
  - At retire, if is_c & j==3'b111 & a_in==pc, set halted=1 and move to state HALT.
  - HALT: rom_req=0, instr_valid=0. Only restart or rst_n exits it.
  - In HALT, restart=1 → pc=RESET_ADDR, halted=0, go to FETCH next cycle.
- Without the macro: no HALT state exists, halted is tied to 0, and the tight loop keeps fetching forever.

Decomposition:
- Shared package hack_pkg holds:
  - state enum {IDLE, FETCH, HOLD, HALT}.
  - Jump-field constants: JGT=3'b001, JEQ=3'b010, JGE=3'b011, JLT=3'b100, JNE=3'b101, JLE=3'b110, JMP=3'b111.
  - Bit positions: C_BIT=15, JMP_LSB=0.
- One sub-module, hack_jump_cond: combinational; inputs instr, zr, ng; output taken. It is reused by the execute stage.

Test Plan:
1. Reset release, rom_ack tied 1, ROM filled with A-instructions, instr_ready tied 1 → rom_addr sequence 0,1,2,3, one new address every 2 cycles; rom_req low in the first cycle after release.
2. instr=16'hE302 (C-instruction, JEQ) with zr=1, a_in=16'h0040 → next rom_addr=16'h0040. Same with zr=0 → next rom_addr=pc+1.
3. pc=16'hFFFF, A-instruction retired → next rom_addr=16'h0000.
4. rom_ack delayed 3 cycles, then instr_ready delayed 2 cycles → rom_req high with stable addr for 4 cycles; instr_valid high with stable instr for 3 cycles.
5. rst_n pulsed low mid-FETCH at pc=16'h0012 → rom_req=0 immediately, pc=0; restart=1 at retire with a taken jump → next addr 0.
6. With HACK_PC_HALT_DETECT_EN: at pc=16'h0005, instr=16'hE387 (C-instruction, JMP), a_in=16'h0005 → halted=1 and rom_req=0 from the next cycle; restart=1 → FETCH at 0.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU front end: FSM encoding, jump-field codes
// and instruction bit positions used by fetch and execute.
package hack_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [2:0] JGT = 3'b001;
    localparam logic [2:0] JEQ = 3'b010;
    localparam logic [2:0] JGE = 3'b011;
    localparam logic [2:0] JLT = 3'b100;
    localparam logic [2:0] JNE = 3'b101;
    localparam logic [2:0] JLE = 3'b110;
    localparam logic [2:0] JMP = 3'b111;

    localparam int unsigned C_BIT   = 15;
    localparam int unsigned JMP_LSB = 0;

endpackage

// File: rtl/hack_jump_cond.sv
// Combinational Hack jump-condition evaluator; shared by fetch and execute stages.
module hack_jump_cond
    import hack_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] instr,
    input  logic             zr,
    input  logic             ng,
    output logic             taken
);

    logic       is_c;
    logic [2:0] j;
    logic       unused_bits;

    assign is_c        = instr[C_BIT];
    assign j           = instr[JMP_LSB +: 3];
    assign unused_bits = ^instr;

    // A-instructions never jump, regardless of their low bits.
    assign taken = is_c & ((j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr));

endmodule

// File: rtl/hack_pc_fetch.sv
// Hack CPU program counter and fetch stage: ROM req/ack in, valid/ready out.
// Optional tight-loop halt detection is enabled by defining HACK_PC_HALT_DETECT_EN.
module hack_pc_fetch
    import hack_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] rom_addr,
    output logic             rom_req,
    input  logic             rom_ack,
    input  logic [WIDTH-1:0] rom_data,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic             zr,
    input  logic             ng,
    input  logic             restart,
    output logic             halted,
    output logic [1:0]       dbg_state
);

    // Handshakes: ROM transfers when rom_req & rom_ack; an instruction retires when
    // instr_valid & instr_ready. Both sides hold address/data stable until transfer.
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             taken;
    logic             halt_hit;

    hack_jump_cond #(.WIDTH(WIDTH)) u_jump_cond (
        .instr (instr_q),
        .zr    (zr),
        .ng    (ng),
        .taken (taken)
    );

`ifdef HACK_PC_HALT_DETECT_EN
    logic halted_q, halted_d;

    assign halt_hit = instr_q[C_BIT] && (instr_q[JMP_LSB +: 3] == JMP) && (a_in == pc_q);
    assign halted   = halted_q;
`else
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef HACK_PC_HALT_DETECT_EN
        halted_d = halted_q;
`endif
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (rom_ack) begin
                    instr_d = rom_data;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    state_d = ST_FETCH;
                    if (restart) begin
                        pc_d = RESET_ADDR;
                    end else if (halt_hit) begin
`ifdef HACK_PC_HALT_DETECT_EN
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
`endif
                    end else if (taken) begin
                        pc_d = a_in;
                    end else begin
                        pc_d = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                end
            end
`ifdef HACK_PC_HALT_DETECT_EN
            ST_HALT: begin
                if (restart) begin
                    pc_d     = RESET_ADDR;
                    halted_d = 1'b0;
                    state_d  = ST_FETCH;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_ADDR;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

`ifdef HACK_PC_HALT_DETECT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end
`endif

    assign rom_addr    = pc_q;
    assign rom_req     = (state_q == ST_FETCH);
    assign instr       = instr_q;
    assign instr_valid = (state_q == ST_HOLD);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_hack_pc_fetch.sv
// Directed self-checking bench for hack_pc_fetch; the halt scenario is checked
// in whichever form HACK_PC_HALT_DETECT_EN selects.
module tb_hack_pc_fetch;

    logic        clk;
    logic        rst_n;
    logic [15:0] rom_addr;
    logic        rom_req;
    logic        rom_ack;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] a_in;
    logic        zr;
    logic        ng;
    logic        restart;
    logic        halted;
    logic [1:0]  dbg_state;

    int n_cmp;
    int n_err;

    logic [15:0] rom_mem [int];

    hack_pc_fetch #(.WIDTH(16), .RESET_ADDR(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_addr    (rom_addr),
        .rom_req     (rom_req),
        .rom_ack     (rom_ack),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .a_in        (a_in),
        .zr          (zr),
        .ng          (ng),
        .restart     (restart),
        .halted      (halted),
        .dbg_state   (dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: unlisted addresses hold an A-instruction equal to the address.
    function automatic logic [15:0] rom_lookup(input logic [15:0] a);
        if (rom_mem.exists(int'(a))) return rom_mem[int'(a)];
        return {1'b0, a[14:0]};
    endfunction

    always @(negedge clk) rom_data = rom_lookup(rom_addr);

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        rom_ack = 1'b1;
        instr_ready = 1'b1;
        a_in = 16'h0000;
        zr = 1'b0;
        ng = 1'b0;
        restart = 1'b0;
        rom_data = 16'h0000;
        rom_mem[16'h0000] = 16'h1234;
        rom_mem[16'h0004] = 16'hE302;
        rom_mem[16'h0040] = 16'hE302;
        rom_mem[16'h0041] = 16'h0007;
        rom_mem[16'h0042] = 16'hE387;
        rom_mem[16'h0005] = 16'hE387;

        // reset state
        tick();
        check_eq("rst_req", {15'd0, rom_req}, 16'd0);
        check_eq("rst_valid", {15'd0, instr_valid}, 16'd0);
        check_eq("rst_halted", {15'd0, halted}, 16'd0);
        check_eq("rst_addr", rom_addr, 16'h0000);
        check_eq("rst_instr", instr, 16'h0000);

        // 1: free-running fetch of A-instructions
        rst_n = 1'b1;
        check_eq("t1_idle_req", {15'd0, rom_req}, 16'd0);
        tick();
        check_eq("t1_req0", {15'd0, rom_req}, 16'd1);
        check_eq("t1_addr0", rom_addr, 16'h0000);
        tick();
        check_eq("t1_valid0", {15'd0, instr_valid}, 16'd1);
        check_eq("t1_instr0", instr, 16'h1234);
        check_eq("t1_hold_req", {15'd0, rom_req}, 16'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_eq("t1_addr", rom_addr, 16'(k));
            tick();
            check_eq("t1_instr", instr, 16'(k));
        end

        // 2: JEQ taken with zr=1, then not taken with zr=0; A-instr with j=111 not taken
        tick();
        check_eq("t2_addr4", rom_addr, 16'h0004);
        tick();
        check_eq("t2_instr", instr, 16'hE302);
        zr = 1'b1;
        a_in = 16'h0040;
        tick();
        check_eq("t2_jeq_taken", rom_addr, 16'h0040);
        tick();
        zr = 1'b0;
        a_in = 16'h0100;
        tick();
        check_eq("t2_jeq_not", rom_addr, 16'h0041);
        tick();
        zr = 1'b1;
        ng = 1'b1;
        tick();
        check_eq("t2_ainstr_not", rom_addr, 16'h0042);
        zr = 1'b0;
        ng = 1'b0;

        // 3: jump to FFFF, then increment wraps to 0
        tick();
        a_in = 16'hFFFF;
        tick();
        check_eq("t3_addr_ffff", rom_addr, 16'hFFFF);
        tick();
        check_eq("t3_instr", instr, 16'h7FFF);
        tick();
        check_eq("t3_wrap", rom_addr, 16'h0000);
        check_eq("t3_halted", {15'd0, halted}, 16'd0);

        // 4: ack late by 3 cycles, ready late by 2 cycles
        rom_ack = 1'b0;
        instr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            check_eq("t4_req", {15'd0, rom_req}, 16'd1);
            check_eq("t4_addr", rom_addr, 16'h0000);
            if (k == 3) rom_ack = 1'b1;
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("t4_valid", {15'd0, instr_valid}, 16'd1);
            check_eq("t4_instr", instr, 16'h1234);
            check_eq("t4_addr_hold", rom_addr, 16'h0000);
            if (k == 2) instr_ready = 1'b1;
        end
        tick();
        check_eq("t4_next", rom_addr, 16'h0001);

        // 5: reach 0x12, reset mid-fetch, then restart beats a taken jump
        rom_mem[16'h0001] = 16'hE387;
        tick();
        a_in = 16'h0012;
        tick();
        check_eq("t5_addr12", rom_addr, 16'h0012);
        rom_ack = 1'b0;
        tick();
        check_eq("t5_req_wait", {15'd0, rom_req}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_async_req", {15'd0, rom_req}, 16'd0);
        check_eq("t5_async_pc", rom_addr, 16'h0000);
        check_eq("t5_async_instr", instr, 16'h0000);
        rom_ack = 1'b1;
        tick();
        rst_n = 1'b1;
        check_eq("t5_idle_req", {15'd0, rom_req}, 16'd0);
        tick();
        check_eq("t5_refetch", rom_addr, 16'h0000);
        check_eq("t5_refetch_req", {15'd0, rom_req}, 16'd1);
        tick();
        tick();
        check_eq("t5_addr1", rom_addr, 16'h0001);
        tick();
        check_eq("t5_instr_jmp", instr, 16'hE387);
        restart = 1'b1;
        a_in = 16'h0077;
        tick();
        restart = 1'b0;
        check_eq("t5_restart", rom_addr, 16'h0000);

        // 6: tight loop at 0x0005
        tick();
        tick();
        tick();
        a_in = 16'h0005;
        tick();
        check_eq("t6_addr5", rom_addr, 16'h0005);
        tick();
        check_eq("t6_instr", instr, 16'hE387);
        tick();
`ifdef HACK_PC_HALT_DETECT_EN
        check_eq("t6_halted", {15'd0, halted}, 16'd1);
        check_eq("t6_req", {15'd0, rom_req}, 16'd0);
        check_eq("t6_valid", {15'd0, instr_valid}, 16'd0);
        tick();
        check_eq("t6_still_halted", {15'd0, halted}, 16'd1);
        check_eq("t6_still_req", {15'd0, rom_req}, 16'd0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_eq("t6_exit_halted", {15'd0, halted}, 16'd0);
        check_eq("t6_exit_req", {15'd0, rom_req}, 16'd1);
        check_eq("t6_exit_addr", rom_addr, 16'h0000);
`else
        check_eq("t6_loop_halted", {15'd0, halted}, 16'd0);
        check_eq("t6_loop_req", {15'd0, rom_req}, 16'd1);
        check_eq("t6_loop_addr", rom_addr, 16'h0005);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
